faddsub_sched: RTL and testbench
================================

# faddsub_sched

Scheduler that shares one pipelined FP subtract unit (`fsub`, latency `NSTAGE`) between two requesters, A and B. Each requester issues add or subtract operations with a valid/ready handshake. Each gets its results back in order through its own result FIFO with valid/ready. The block performs round-robin arbitration, converts add into subtract, tracks in-flight operations, and reserves result-FIFO space before issue because the shared pipeline cannot stall.

## Interface
Parameters:
- `NSTAGE`, 2: latency of the shared unit, in clock edges from input to valid output.
- `DEPTH`, 4: result FIFO depth per requester; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `a_valid` in 1, `a_ready` out 1, `a_sub` in 1 (1 = x1−x2, 0 = x1+x2), `a_x1` in 32, `a_x2` in 32: requester A issue port.
- `a_rvalid` out 1, `a_rready` in 1, `a_y` out 32, `a_ovf` out 1: requester A result port.
- `b_*`: identical set of ports for requester B.
- `pipe_x1` out 32, `pipe_x2` out 32: operands to the shared `fsub`.
- `pipe_y` in 32, `pipe_ovf` in 1: outputs of the shared `fsub`.

## Operation
- Occupancy `occ_a` = entries in A's FIFO + in-flight A operations, range 0..DEPTH. `credit_a = occ_a < DEPTH`. B uses the same rules.
- Priority pointer `prio`, 1 bit; the reset value selects A.
- Ready logic, combinational:
  - `a_ready = credit_a && !(b_valid && credit_b && prio==B)`.
  - B is symmetric.
  - `a_ready` never depends on `a_valid`.
- Grant: at most one issue per cycle.
  - A requester is issued when its valid and ready are both high.
  - On every grant, `prio` moves to the non-granted requester.
  - With no grant, `prio` holds.
- Operand drive in the grant cycle, combinational:
  - `pipe_x1` = selected x1.
  - `pipe_x2` = x2 for a subtract, `{~x2[31], x2[30:0]}` for an add.
  - With no grant, both are driven to 0.
- Tracking: a shift register of NSTAGE entries `{vld, id}`.
  - Entry 0 captures the grant at the end of the grant cycle.
  - Entries advance one stage per clock.
  - Entry NSTAGE−1 being valid means `pipe_y`/`pipe_ovf` are valid in the current cycle for `id`.
  - That result is written into `id`'s FIFO at the end of the cycle.
- Space is reserved at issue, so a FIFO write never finds the FIFO full. This is a checked invariant: assert on write-when-full.
- Result FIFO:
  - `rvalid` = not empty.
  - Pop on `rvalid && rready`.
  - `a_y`/`a_ovf` are the head entry, forced to 0 while `a_rvalid`=0.
  - Pointers are log2(DEPTH)+1 bits; wrap-around is natural modular arithmetic.
- Occupancy counters are registered:
  - +1 on grant, −1 on pop, net 0 when both happen in the same cycle.
  - A pop frees credit from the next cycle on.
- The shared unit is not cleared by the scheduler's reset. Stale `pipe_y` is ignored because the tracking register resets to all-invalid.

## Timing
- Issue-to-result:
  - Grant in cycle t.
  - `pipe_y` valid in cycle t+NSTAGE.
  - `rvalid` high earliest in cycle t+NSTAGE+1, which is 3 cycles for the default.
- Throughput is one operation per cycle in aggregate. A lone requester with an emptying FIFO issues every cycle.
- Per-requester results arrive in issue order. There is no ordering between A and B.
- Simultaneous events:
  - Grant, FIFO write and pop on the same requester in one cycle are all legal.
  - Counter and FIFO count stay consistent.
  - Full FIFO plus pop: the write from the pipe lands in the freed slot.
- Reset values:
  - `a/b_rvalid`=0, `a/b_y`=0, `a/b_ovf`=0.
  - `pipe_x1`/`pipe_x2`=0 unless a grant is combinationally present.
  - Occupancies 0, so `a_ready`/`b_ready` read 1 in the first cycle after reset.
  - `prio`=A, tracking register all-invalid, FIFOs empty.
- Reset mid-operation:
  - All in-flight and queued results are discarded.
  - Those results never appear on `rvalid`, including `pipe_y` values that arrive after reset release.
- While `rst`=1 no grant occurs: `a_ready` and `b_ready` are forced to 0.

## Test plan
- **A add.** A adds 0x3F800000 + 0x40000000 granted in cycle t. Expect `pipe_x2`=0xC0000000 in cycle t and `a_rvalid`=1 in cycle t+3 with `a_y`=0x40400000, `a_ovf`=0. B stays silent.
- **B subtract.** B computes 0x3F800000 − 0x40000000. Expect `pipe_x2`=0x40000000 and `b_y`=0xBF800000.
- **Contention.** Both valid every cycle with rready=1 from reset. Expect grants A,B,A,B… and each side's results in its own issue order. A 3-cycle B-only window gives B three consecutive grants.
- **Backpressure.** `a_rready`=0 with A valid continuously, DEPTH=4. Expect exactly 4 accepts, then `a_ready`=0 and B still granted every cycle. Pulse `a_rready` for one cycle: one pop, `a_ready`=1 the next cycle, and a fifth accept.
- **Overflow.** A adds 0x7F7FFFFF + 0x7F7FFFFF. Expect `a_y`=0x7F800000, `a_ovf`=1.
- **Reset mid-flight.** Grant two A operations, then assert `rst` for 1 cycle one cycle later. Expect no `a_rvalid` for 10 cycles, ready=1 after release, and the next operation returning its correct result in NSTAGE+1 cycles.

Source files
------------

// File: rtl/faddsub_sched.sv
// faddsub_sched
// Shares one pipelined FP subtract unit (fixed latency NSTAGE, cannot stall)
// between two requesters, A and B. Adds are turned into subtracts by
// flipping the sign of x2. Each requester gets its results back in order
// through a private result FIFO.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_valid/a_ready           A issue handshake; a_sub selects x1-x2 (1) or x1+x2 (0)
//   a_x1, a_x2                A operands (IEEE single)
//   a_rvalid/a_rready         A result handshake; a_y/a_ovf are the head result
//   b_*                       same set for requester B
//   pipe_x1, pipe_x2          operands to the shared unit (0 when nothing is issued)
//   pipe_y, pipe_ovf          result of the shared unit, NSTAGE edges after issue
//
// Flow control: every requester owns an occupancy count covering both its
// queued results and its in-flight operations. An operation is issued only
// while that count is below DEPTH, so the FIFO slot for its result is
// reserved up front and the pipe never has to be held.
module faddsub_sched #(
  parameter int NSTAGE = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  // requester A
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_sub,
  input  logic [31:0] a_x1,
  input  logic [31:0] a_x2,
  output logic        a_rvalid,
  input  logic        a_rready,
  output logic [31:0] a_y,
  output logic        a_ovf,
  // requester B
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_sub,
  input  logic [31:0] b_x1,
  input  logic [31:0] b_x2,
  output logic        b_rvalid,
  input  logic        b_rready,
  output logic [31:0] b_y,
  output logic        b_ovf,
  // shared subtract unit
  output logic [31:0] pipe_x1,
  output logic [31:0] pipe_x2,
  input  logic [31:0] pipe_y,
  input  logic        pipe_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = DEPTH[PW-1:0];

  // Requester-indexed views of the ports: index 0 is A, index 1 is B.
  logic [1:0]       req_valid;
  logic [1:0]       req_sub;
  logic [1:0][31:0] req_x1;
  logic [1:0][31:0] req_x2;
  logic [1:0]       rsp_rready;
  logic [1:0]       credit;
  logic [1:0]       ready;
  logic [1:0]       grant;
  logic [1:0]       rsp_rvalid;
  logic [1:0][31:0] rsp_y;
  logic [1:0]       rsp_ovf;

  assign req_valid  = {b_valid, a_valid};
  assign req_sub    = {b_sub, a_sub};
  assign req_x1     = {b_x1, a_x1};
  assign req_x2     = {b_x2, a_x2};
  assign rsp_rready = {b_rready, a_rready};

  assign a_ready  = ready[0];
  assign b_ready  = ready[1];
  assign a_rvalid = rsp_rvalid[0];
  assign b_rvalid = rsp_rvalid[1];
  assign a_y      = rsp_y[0];
  assign b_y      = rsp_y[1];
  assign a_ovf    = rsp_ovf[0];
  assign b_ovf    = rsp_ovf[1];

  // Priority pointer: 0 favours A, 1 favours B.
  logic prio_q, prio_d;

  // Tracking shift register: one {vld, id} entry per pipe stage.
  logic [NSTAGE-1:0] trk_vld_q, trk_vld_d;
  logic [NSTAGE-1:0] trk_id_q, trk_id_d;

  // Result leaving the last pipe stage this cycle, and its owner.
  logic pipe_out_vld;
  logic pipe_out_id;

  assign pipe_out_vld = trk_vld_q[NSTAGE-1];
  assign pipe_out_id  = trk_id_q[NSTAGE-1];

  // ------------------------------------------------------------------
  // Per-requester credit, ready, occupancy and result FIFO
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : gen_req
    localparam int   OTHER = 1 - gi;
    localparam logic MY_ID = (gi == 1);

    logic [PW-1:0] occ_q, occ_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [32:0]   mem_q [DEPTH];   // {ovf, y}
    logic [32:0]   head;
    logic          wr_en;
    logic          pop;
    logic          empty;
    logic          full;

    assign credit[gi] = occ_q < DEPTH_P;

    // Yield only when the other side is asking, able to take a slot, and
    // currently holds priority. Never looks at our own valid.
    assign ready[gi] = !rst && credit[gi] &&
                       !(req_valid[OTHER] && credit[OTHER] && (prio_q == OTHER[0]));

    assign grant[gi] = req_valid[gi] && ready[gi];

    assign wr_en = pipe_out_vld && (pipe_out_id == MY_ID);
    assign empty = (wptr_q == rptr_q);
    assign full  = ((wptr_q - rptr_q) == DEPTH_P);
    assign pop   = !empty && rsp_rready[gi];
    assign head  = mem_q[rptr_q[AW-1:0]];

    assign rsp_rvalid[gi] = !empty;
    assign rsp_y[gi]      = empty ? 32'd0 : head[31:0];
    assign rsp_ovf[gi]    = empty ? 1'b0  : head[32];

    always_comb begin
      occ_d  = occ_q + {{AW{1'b0}}, grant[gi]} - {{AW{1'b0}}, pop};
      wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
      rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        occ_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        occ_q  <= occ_d;
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wptr_q[AW-1:0]] <= {pipe_ovf, pipe_y};
      end
    end

    // Reservation at issue guarantees a free slot for every pipe result.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(wr_en && full));
  end

  // ------------------------------------------------------------------
  // Arbitration and operand drive
  // ------------------------------------------------------------------
  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  logic [31:0] sel_x1;
  logic [31:0] sel_x2;
  logic        sel_sub;

  always_comb begin
    sel_x1  = grant[1] ? req_x1[1]  : req_x1[0];
    sel_x2  = grant[1] ? req_x2[1]  : req_x2[0];
    sel_sub = grant[1] ? req_sub[1] : req_sub[0];
    pipe_x1 = 32'd0;
    pipe_x2 = 32'd0;
    if (|grant) begin
      pipe_x1 = sel_x1;
      // x1 + x2 is computed as x1 - (-x2): flip the sign bit for an add.
      pipe_x2 = sel_sub ? sel_x2 : {~sel_x2[31], sel_x2[30:0]};
    end
  end

  // ------------------------------------------------------------------
  // Tracking register
  // ------------------------------------------------------------------
  always_comb begin
    trk_vld_d    = '0;
    trk_id_d     = '0;
    trk_vld_d[0] = |grant;
    trk_id_d[0]  = grant[1];
    for (int i = 1; i < NSTAGE; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
  end

  // Clearing the valid bits on reset is what discards stale pipe_y values
  // that are still travelling through the (unreset) shared unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= 1'b0;
      trk_vld_q <= '0;
      trk_id_q  <= '0;
    end else begin
      prio_q    <= prio_d;
      trk_vld_q <= trk_vld_d;
      trk_id_q  <= trk_id_d;
    end
  end

endmodule

// File: tb/tb_faddsub_sched.sv
// Testbench for faddsub_sched: stand-in FP subtract pipe, cycle-level
// behavioural model of the scheduler (queues of expected results per
// requester), directed scenarios with literal expectations and a random phase.
module tb_faddsub_sched;
  localparam int NSTAGE = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_sub, a_rvalid, a_rready, a_ovf;
  logic [31:0] a_x1, a_x2, a_y;
  logic        b_valid, b_ready, b_sub, b_rvalid, b_rready, b_ovf;
  logic [31:0] b_x1, b_x2, b_y;
  logic [31:0] pipe_x1, pipe_x2, pipe_y;
  logic        pipe_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  faddsub_sched #(.NSTAGE(NSTAGE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_sub(a_sub), .a_x1(a_x1), .a_x2(a_x2),
    .a_rvalid(a_rvalid), .a_rready(a_rready), .a_y(a_y), .a_ovf(a_ovf),
    .b_valid(b_valid), .b_ready(b_ready), .b_sub(b_sub), .b_x1(b_x1), .b_x2(b_x2),
    .b_rvalid(b_rvalid), .b_rready(b_rready), .b_y(b_y), .b_ovf(b_ovf),
    .pipe_x1(pipe_x1), .pipe_x2(pipe_x2), .pipe_y(pipe_y), .pipe_ovf(pipe_ovf)
  );

  // ---------------- IEEE single helpers via double-precision reals ---------
  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [7:0] e;
    e = s[30:23];
    if (e == 8'd0) return {s[31], 63'd0};
    if (e == 8'hFF) return {s[31], 11'h7FF, s[22:0], 29'd0};
    return {s[31], 11'(e) + 11'd896, s[22:0], 29'd0};
  endfunction

  // Round-to-nearest-even back to single; returns {ovf, y}.
  function automatic logic [32:0] d2s(input logic [63:0] d);
    logic [10:0] de;
    int          e;
    logic [23:0] m;
    logic [28:0] rem;
    de = d[62:52];
    if (de == 11'h7FF) return {1'b1, d[63], 8'hFF, 23'd0};
    if (de == 11'd0) return {1'b0, d[63], 31'd0};
    e = int'(de) - 896;
    if (e <= 0) return {1'b0, d[63], 31'd0};
    m   = {1'b0, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = 24'd0;
    end
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    return {1'b0, d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [32:0] fp_sub(input logic [31:0] x1, input logic [31:0] x2);
    real r;
    r = $bitstoreal(s2d(x1)) - $bitstoreal(s2d(x2));
    return d2s($realtobits(r));
  endfunction

  // What a requester asked for, in plain arithmetic.
  function automatic logic [32:0] fp_op(input logic sub, input logic [31:0] x1, input logic [31:0] x2);
    real ra, rb, r;
    ra = $bitstoreal(s2d(x1));
    rb = $bitstoreal(s2d(x2));
    r  = sub ? (ra - rb) : (ra + rb);
    return d2s($realtobits(r));
  endfunction

  // ---------------- stand-in shared subtract unit (never reset) ------------
  logic [32:0] fs_q [NSTAGE];
  always @(posedge clk) begin
    fs_q[0] <= fp_sub(pipe_x1, pipe_x2);
    for (int i = 1; i < NSTAGE; i++) fs_q[i] <= fs_q[i-1];
  end
  assign pipe_y   = fs_q[NSTAGE-1][31:0];
  assign pipe_ovf = fs_q[NSTAGE-1][32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ------------------
  typedef struct packed {
    logic [32:0] res;
    int unsigned avail;   // first cycle the result may show on rvalid
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  bit          prio_m = 1'b0;   // 0: A favoured
  int unsigned cyc = 0;

  always @(negedge clk) begin
    bit          ca, cb, era, erb, ga, gb, va, vb;
    logic [31:0] ex1, ex2;
    logic [32:0] ha, hb;
    cyc++;
    if (rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      qa.delete();
      qb.delete();
      prio_m = 1'b0;
    end else begin
      ca  = qa.size() < DEPTH;
      cb  = qb.size() < DEPTH;
      era = ca && !(b_valid && cb && prio_m);
      erb = cb && !(a_valid && ca && !prio_m);
      chk("a_ready", a_ready, era);
      chk("b_ready", b_ready, erb);
      ga = a_valid && era;
      gb = b_valid && erb;
      ex1 = 32'd0;
      ex2 = 32'd0;
      if (ga) begin
        ex1 = a_x1;
        ex2 = a_sub ? a_x2 : (a_x2 ^ 32'h8000_0000);
      end else if (gb) begin
        ex1 = b_x1;
        ex2 = b_sub ? b_x2 : (b_x2 ^ 32'h8000_0000);
      end
      chk("pipe_x1", pipe_x1, ex1);
      chk("pipe_x2", pipe_x2, ex2);

      va = (qa.size() > 0) && (qa[0].avail <= cyc);
      vb = (qb.size() > 0) && (qb[0].avail <= cyc);
      ha = va ? qa[0].res : 33'd0;
      hb = vb ? qb[0].res : 33'd0;
      chk("a_rvalid", a_rvalid, va);
      chk("a_y", a_y, ha[31:0]);
      chk("a_ovf", a_ovf, ha[32]);
      chk("b_rvalid", b_rvalid, vb);
      chk("b_y", b_y, hb[31:0]);
      chk("b_ovf", b_ovf, hb[32]);

      if (va && a_rready) begin
        $display("txn A y=%08h ovf=%0b cycle=%0d", ha[31:0], ha[32], cyc);
        void'(qa.pop_front());
      end
      if (vb && b_rready) begin
        $display("txn B y=%08h ovf=%0b cycle=%0d", hb[31:0], hb[32], cyc);
        void'(qb.pop_front());
      end
      if (ga) qa.push_back('{res: fp_op(a_sub, a_x1, a_x2), avail: cyc + NSTAGE + 1});
      if (gb) qb.push_back('{res: fp_op(b_sub, b_x1, b_x2), avail: cyc + NSTAGE + 1});
      if (ga) prio_m = 1'b1;
      else if (gb) prio_m = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; a_rready = 0; b_rready = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic rand_ops();
    a_sub = 1'($urandom_range(0, 1)); a_x1 = rnd_fp(); a_x2 = rnd_fp();
    b_sub = 1'($urandom_range(0, 1)); b_x1 = rnd_fp(); b_x2 = rnd_fp();
  endtask

  task automatic drain(input int n);
    a_valid = 0; b_valid = 0; a_rready = 1; b_rready = 1;
    repeat (n) step();
    a_rready = 0; b_rready = 0;
  endtask

  task automatic run_single(input bit is_b, input bit sub, input logic [31:0] x1,
                            input logic [31:0] x2, input logic [31:0] exp_x2,
                            input logic [31:0] exp_y, input bit exp_ovf, input string tag);
    idle();
    if (is_b) begin b_valid = 1; b_sub = sub; b_x1 = x1; b_x2 = x2; end
    else      begin a_valid = 1; a_sub = sub; a_x1 = x1; a_x2 = x2; end
    @(negedge clk);
    chk({tag, "_ready"}, is_b ? b_ready : a_ready, 1);
    chk({tag, "_pipe_x1"}, pipe_x1, x1);
    chk({tag, "_pipe_x2"}, pipe_x2, exp_x2);
    step();
    a_valid = 0; b_valid = 0;
    step();
    @(negedge clk);
    chk({tag, "_rvalid_early"}, is_b ? b_rvalid : a_rvalid, 0);
    step();
    @(negedge clk);
    chk({tag, "_rvalid"}, is_b ? b_rvalid : a_rvalid, 1);
    chk({tag, "_y"}, is_b ? b_y : a_y, exp_y);
    chk({tag, "_ovf"}, is_b ? b_ovf : a_ovf, exp_ovf);
    chk({tag, "_other_silent"}, is_b ? a_rvalid : b_rvalid, 0);
    step();
    a_rready = 1; b_rready = 1;
    step();
    a_rready = 0; b_rready = 0;
  endtask

  int acc;

  initial begin
    rst = 1; idle();
    a_sub = 0; a_x1 = 0; a_x2 = 0; b_sub = 0; b_x1 = 0; b_x2 = 0;
    do_reset(3);

    // Reset state
    @(negedge clk);
    chk("init_a_ready", a_ready, 1);
    chk("init_b_ready", b_ready, 1);
    chk("init_a_rvalid", a_rvalid, 0);
    chk("init_a_y", a_y, 0);
    chk("init_pipe_x1", pipe_x1, 0);
    step();

    // Directed single operations
    run_single(0, 0, 32'h3F80_0000, 32'h4000_0000, 32'hC000_0000, 32'h4040_0000, 0, "a_add");
    run_single(1, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'hBF80_0000, 0, "b_sub");
    run_single(0, 0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1, "a_ovf");

    // Contention: alternating grants from reset, then a B-only window
    do_reset(1);
    a_rready = 1; b_rready = 1; a_valid = 1; b_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      @(negedge clk);
      chk("cont_a_grant", a_ready, (i % 2) == 0);
      chk("cont_b_grant", b_ready, (i % 2) == 1);
      step();
    end
    a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      @(negedge clk);
      chk("cont_b_only", b_ready, 1);
      step();
    end
    drain(8);

    // Backpressure on A
    do_reset(1);
    a_rready = 0; b_rready = 1; a_valid = 1; b_valid = 1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      @(negedge clk);
      if (a_ready) acc++;
      if (i >= 8) chk("bp_b_every_cycle", b_ready, 1);
      step();
    end
    chk("bp_accepts", acc, 4);
    a_rready = 1;
    @(negedge clk);
    chk("bp_pop_cycle_a_ready", a_ready, 0);
    step();
    a_rready = 0;
    rand_ops();
    @(negedge clk);
    chk("bp_fifth_accept", a_ready, 1);
    step();
    @(negedge clk);
    chk("bp_full_again", a_ready, 0);
    step();
    drain(12);

    // Reset in the middle of two in-flight A operations
    do_reset(1);
    a_rready = 1; a_valid = 1; b_valid = 0;
    rand_ops(); step();
    rand_ops(); step();
    a_valid = 0; rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_rvalid", a_rvalid, 0);
      if (i == 0) chk("midrst_ready", a_ready, 1);
      step();
    end
    run_single(0, 1, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, "post_rst");

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_ops();
      a_valid  = ($urandom_range(0, 9) < 7);
      b_valid  = ($urandom_range(0, 9) < 7);
      a_rready = ($urandom_range(0, 9) < 6);
      b_rready = ($urandom_range(0, 9) < 6);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;
    drain(15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
